uart_cmd_receiver: RTL and testbench

UART_CMD_RECEIVER -- requirements
Module: uart_cmd_receiver

---
 rtl/uart_cmd_receiver.sv | 182 ++++++++++++++++++
 tb/tb_uart_cmd_receiver.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_receiver.sv
// 8N1 UART receiver feeding a two-byte command parser (letter + digit '0'..'7').
// All strobes are registered one-cycle pulses; decoded command/multiplier hold between updates.
module uart_cmd_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic [2:0] drive_command,
    output logic [2:0] multiplier,
    output logic       cmd_valid,
    output logic       parse_error
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic {
        P_CMD,
        P_MULT
    } p_state_t;

    logic            sync1, line;
    rx_state_t       rx_state;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    p_state_t        p_state;
    logic [2:0]      cmd_latch;
    logic [TW-1:0]   tmo_cnt;

    // {valid, code} for a command letter
    function automatic logic [3:0] decode(input logic [7:0] b);
        case (b)
            8'h53:   decode = 4'b1_000;
            8'h46:   decode = 4'b1_001;
            8'h42:   decode = 4'b1_010;
            8'h4C:   decode = 4'b1_011;
            8'h52:   decode = 4'b1_100;
            default: decode = 4'b0_000;
        endcase
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        is_digit = (b >= 8'h30) && (b <= 8'h37);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync1 <= uart_in;
            line  <= sync1;
        end
    end

    // Receiver: sample at bit midpoints, counted from the start-bit centre
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state    <= RX_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    bit_cnt <= '0;
                    if (!line) rx_state <= RX_START;
                end
                RX_START: begin
                    if (bit_cnt == BIT_MID) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        rx_state <= line ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        shift   <= {line, shift[7:1]};
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                        else                 bit_idx  <= bit_idx + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (line) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            rx_state    <= RX_WAIT_HIGH;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    bit_cnt <= '0;
                    if (line) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Parser: reacts only to the receiver strobes and its own timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            p_state       <= P_CMD;
            cmd_latch     <= '0;
            tmo_cnt       <= '0;
            drive_command <= '0;
            multiplier    <= '0;
            cmd_valid     <= 1'b0;
            parse_error   <= 1'b0;
        end else begin
            cmd_valid   <= 1'b0;
            parse_error <= 1'b0;
            case (p_state)
                P_CMD: begin
                    tmo_cnt <= '0;
                    if (rx_valid) begin
                        if (decode(rx_data)[3]) begin
                            cmd_latch <= decode(rx_data)[2:0];
                            p_state   <= P_MULT;
                        end else begin
                            parse_error <= 1'b1;
                        end
                    end
                end
                P_MULT: begin
                    if (rx_valid) begin
                        if (is_digit(rx_data)) begin
                            drive_command <= cmd_latch;
                            multiplier    <= rx_data[2:0];
                            cmd_valid     <= 1'b1;
                        end else begin
                            parse_error <= 1'b1;
                        end
                        p_state <= P_CMD;
                    end else if (frame_error || tmo_cnt == TMO_LAST) begin
                        parse_error <= 1'b1;
                        p_state     <= P_CMD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: p_state <= P_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Scoreboard bench: expected strobes are queued as frames are driven and
// retired by a negedge monitor, which also checks strobe width and latency.
module tb_uart_cmd_receiver;

    localparam int CPB = 100;
    localparam int TMO = 3000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_error, cmd_valid, parse_error;
    logic [2:0] drive_command, multiplier;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_ev = 0;

    logic [7:0] rxq[$];
    logic [5:0] cmdq[$];
    bit         parseq[$];   // 1: must follow a receiver strobe by one cycle
    bit         frameq[$];
    logic       prev_rxv = 0, prev_fe = 0, prev_cv = 0, prev_pe = 0;

    uart_cmd_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .reset(reset), .uart_in(uart_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error),
        .drive_command(drive_command), .multiplier(multiplier),
        .cmd_valid(cmd_valid), .parse_error(parse_error)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && prev_rxv) chk("rx_valid_width", 2, 1);
            if (frame_error && prev_fe) chk("frame_error_width", 2, 1);
            if (cmd_valid && prev_cv) chk("cmd_valid_width", 2, 1);
            if (parse_error && prev_pe) chk("parse_error_width", 2, 1);
            if (rx_valid) begin
                if (rxq.size() == 0) chk("rx_unexpected", {24'h0, rx_data}, 32'hffff_ffff);
                else chk("rx_data", {24'h0, rx_data}, {24'h0, rxq.pop_front()});
            end
            if (frame_error) begin
                if (frameq.size() == 0) chk("frame_unexpected", 1, 0);
                else void'(frameq.pop_front());
            end
            if (cmd_valid) begin
                chk("cmd_latency", cyc - last_ev, 1);
                if (cmdq.size() == 0) chk("cmd_unexpected", {26'h0, drive_command, multiplier}, 32'hffff_ffff);
                else chk("cmd_mult", {26'h0, drive_command, multiplier}, {26'h0, cmdq.pop_front()});
            end
            if (parse_error) begin
                if (parseq.size() == 0) chk("parse_unexpected", 1, 0);
                else if (parseq.pop_front()) chk("parse_latency", cyc - last_ev, 1);
            end
            if (rx_valid || frame_error) last_ev = cyc;
        end
        prev_rxv = rx_valid;
        prev_fe  = frame_error;
        prev_cv  = cmd_valid;
        prev_pe  = parse_error;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) rxq.push_back(b);
        else         frameq.push_back(1'b1);
        uart_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            tick(CPB);
        end
        uart_in = stop_ok;
        tick(CPB);
        uart_in = 1'b1;
        tick(CPB);
    endtask

    task automatic good_cmd(input logic [7:0] c, input logic [7:0] m, input logic [2:0] ec);
        cmdq.push_back({ec, m[2:0]});
        send_byte(c, 1);
        send_byte(m, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rx_data"}, {24'h0, rx_data}, 0);
        chk({tag, "_cmd"}, {29'h0, drive_command}, 0);
        chk({tag, "_mult"}, {29'h0, multiplier}, 0);
        chk({tag, "_strobes"}, {28'h0, rx_valid, frame_error, cmd_valid, parse_error}, 0);
    endtask

    initial begin
        tick(3);
        chk_zero("reset");
        reset = 1'b0;
        tick(5);

        good_cmd("F", "3", 3'd1);

        // short low pulse on an idle line must not start a frame
        uart_in = 1'b0;
        tick(40);
        uart_in = 1'b1;
        tick(3 * CPB);
        chk("glitch_rx_data", {24'h0, rx_data}, 32'h33);

        send_byte(8'h52, 0);
        chk("frame_rx_data", {24'h0, rx_data}, 32'h33);
        good_cmd("B", "5", 3'd2);

        parseq.push_back(1);
        send_byte("F", 1);
        send_byte("9", 1);
        chk("bad_digit_cmd", {29'h0, drive_command}, 2);
        chk("bad_digit_mult", {29'h0, multiplier}, 5);

        parseq.push_back(1);
        send_byte("S", 1);
        send_byte("F", 1);

        parseq.push_back(1);
        send_byte("L", 1);
        send_byte(8'h33, 0);

        parseq.push_back(0);
        send_byte("L", 1);
        tick(TMO + 200);
        chk("timeout_pending", parseq.size(), 0);
        good_cmd("R", "2", 3'd4);

        // abandon a frame after three data bits of 'S' (0x53: bits 1,1,0)
        uart_in = 1'b0;
        tick(CPB);
        uart_in = 1'b1;
        tick(2 * CPB);
        uart_in = 1'b0;
        tick(CPB);
        reset = 1'b1;
        uart_in = 1'b1;
        tick(2);
        chk_zero("midbyte_reset");
        reset = 1'b0;
        tick(CPB);
        good_cmd("S", "0", 3'd0);

        tick(2 * CPB);
        chk("rxq_drained", rxq.size(), 0);
        chk("cmdq_drained", cmdq.size(), 0);
        chk("parseq_drained", parseq.size(), 0);
        chk("frameq_drained", frameq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
